ahb_byte_arbiter: RTL
=====================

AHB_BYTE_ARBITER -- requirements
Module: ahb_byte_arbiter

Interface
REQ-001 Parameter: BASE_ADDR, 32'h2000_0000, AHB address added to every 16-bit requester byte address.
REQ-002 Port: clk  input  1  single clock for all logic.
REQ-003 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 Ports: r0_read, r0_write  input  1 each  requester 0 read/write strobe, held until r0_ready.
REQ-005 Ports: r0_addr  input  16, r0_wdata  input  8  requester 0 byte address and write data.
REQ-006 Ports: r0_rdata  output  8, r0_ready  output  1  requester 0 read data and one-cycle completion pulse.
REQ-007 Ports: r1_read, r1_write, r1_addr, r1_wdata, r1_rdata, r1_ready  same directions/widths as requester 0.
REQ-008 Ports: HADDR  output  32, HTRANS  output  2, HSIZE  output  2, HWRITE  output  1, HWDATA  output  32  AHB-Lite master outputs.
REQ-009 Ports: HRDATA  input  32, HREADY  input  1  AHB-Lite slave response.
REQ-010 Port: grant  output  2  one-hot owner of current transfer, 2'b00 when idle.

Function
REQ-011 FSM states IDLE, ADDR, DATA, DONE; IDLE->ADDR on any request; ADDR->DATA when HREADY=1; DATA->DONE when HREADY=1; DONE->IDLE unconditionally.
REQ-012 In IDLE, a single requester is granted; with both requesting, grant goes to the requester not granted last (round-robin); after reset, requester 0 wins the first tie.
REQ-013 On grant, address, write data and direction are latched; later requester input changes do not affect the transfer.
REQ-014 With read and write both high, the transfer is a write.
REQ-015 ADDR: HTRANS=2'b10 (NONSEQ), HSIZE=2'b00 (byte), HADDR=BASE_ADDR+{16'h0,addr}, HWRITE=direction; all outputs held while HREADY=0.
REQ-016 DATA: HTRANS=2'b00 (IDLE); HWDATA={4{wdata}} for writes, 32'h0 for reads; HWDATA held while HREADY=0.
REQ-017 On DATA with HREADY=1 and a read, the byte lane HRDATA[8*addr[1:0]+7 -: 8] is captured into the owner's rdata register.
REQ-018 rN_rdata holds its value until the next read completion for that requester; writes leave it unchanged.
REQ-019 DONE: owner's ready=1 for exactly one cycle; the other ready stays 0.
REQ-020 Latency with zero wait states: request sampled in IDLE at cycle 0, ready=1 in cycle 3; each HREADY=0 cycle adds one cycle.
REQ-021 A requester deasserts its strobe on the clock edge where it samples ready=1; a strobe still high in the following IDLE starts a new transfer.
REQ-022 The non-granted requester's pending strobe is served in the next IDLE; no request is dropped.
REQ-023 HTRANS is never NONSEQ outside ADDR; there are no back-to-back or pipelined transfers.
REQ-024 grant is one-hot from ADDR through DONE and 2'b00 in IDLE.

Reset
REQ-025 resetn=0 forces IDLE immediately: HTRANS=2'b00, HADDR=BASE_ADDR, HSIZE=2'b00, HWRITE=0, HWDATA=0, ready=0, rdata=8'h00, grant=2'b00, round-robin pointer = requester 0.
REQ-026 Reset during ADDR or DATA abandons the transfer with no ready pulse; outputs take reset values asynchronously.

Structure
REQ-027 Shared package ahb_pkg holds HTRANS_IDLE, HTRANS_NONSEQ, HSIZE_BYTE constants and the FSM state typedef.
REQ-028 Round-robin selection is one sub-module, rr_arb2 (two requests, last-grant pointer, one-hot grant).

Verification
REQ-029 r0_read addr 16'h0005, HRDATA=32'hDDCCBBAA, HREADY=1 -> HADDR=32'h2000_0005 NONSEQ, r0_rdata=8'hBB, r0_ready in cycle 3.
REQ-030 r1_write addr 16'h0102 data 8'h5A, HREADY=0 for 2 DATA cycles -> HWDATA=32'h5A5A5A5A held, HWRITE=1, r1_ready in cycle 5.
REQ-031 r0_read and r1_read asserted together, repeatedly -> grants alternate 01,10,01,10; each ready exactly once per request.
REQ-032 r0_read and r0_write both high -> HWRITE=1; r0_rdata unchanged.
REQ-033 resetn low during DATA -> HTRANS=00 and ready=0 immediately; after release, a new r1 request completes normally with grant=10.

Source files
------------

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite constants, arbiter FSM state type and byte-lane helper
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HSIZE_BYTE    = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    DONE = 2'b11
  } arb_state_t;

  // Little-endian lane pick: lane 0 is HRDATA[7:0].
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with last-grant pointer and one-hot grant
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index of the requester that wins the next tie.
  logic prio_q;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prio_q <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      prio_q <= grant[0];
    end
  end

endmodule

// File: rtl/ahb_byte_arbiter.sv
// rtl/ahb_byte_arbiter.sv - two byte requesters shared onto one AHB-Lite master, one transfer at a time
module ahb_byte_arbiter
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        r0_read,
  input  logic        r0_write,
  input  logic [15:0] r0_addr,
  input  logic [7:0]  r0_wdata,
  output logic [7:0]  r0_rdata,
  output logic        r0_ready,
  input  logic        r1_read,
  input  logic        r1_write,
  input  logic [15:0] r1_addr,
  input  logic [7:0]  r1_wdata,
  output logic [7:0]  r1_rdata,
  output logic        r1_ready,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [1:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  output logic [1:0]  grant
);

  arb_state_t  state_q, state_d;
  logic [1:0]  req;
  logic [1:0]  arb_grant;
  logic        take;
  logic        capture;

  logic [1:0]  owner_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic [7:0]  r0_rdata_q;
  logic [7:0]  r1_rdata_q;

  assign req = {r1_read | r1_write, r0_read | r0_write};

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .advance (state_q == IDLE),
    .grant   (arb_grant)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are decoded from state so an async reset drops them immediately.
  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    capture  = 1'b0;
    HTRANS   = HTRANS_IDLE;
    HWRITE   = 1'b0;
    HWDATA   = 32'h0;
    grant    = 2'b00;
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_grant != 2'b00) begin
          take    = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        HTRANS = HTRANS_NONSEQ;
        HWRITE = write_q;
        grant  = owner_q;
        if (HREADY) begin
          state_d = DATA;
        end
      end
      DATA: begin
        grant  = owner_q;
        HWDATA = write_q ? {4{wdata_q}} : 32'h0;
        if (HREADY) begin
          capture = ~write_q;
          state_d = DONE;
        end
      end
      DONE: begin
        grant    = owner_q;
        r0_ready = owner_q[0];
        r1_ready = owner_q[1];
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write wins when a requester raises both strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= 2'b00;
      addr_q  <= 16'h0;
      wdata_q <= 8'h0;
      write_q <= 1'b0;
    end else if (take) begin
      owner_q <= arb_grant;
      addr_q  <= arb_grant[0] ? r0_addr  : r1_addr;
      wdata_q <= arb_grant[0] ? r0_wdata : r1_wdata;
      write_q <= arb_grant[0] ? r0_write : r1_write;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r0_rdata_q <= 8'h00;
      r1_rdata_q <= 8'h00;
    end else if (capture) begin
      if (owner_q[0]) begin
        r0_rdata_q <= byte_lane(HRDATA, addr_q[1:0]);
      end else begin
        r1_rdata_q <= byte_lane(HRDATA, addr_q[1:0]);
      end
    end
  end

  assign HADDR    = BASE_ADDR + {16'h0, addr_q};
  assign HSIZE    = HSIZE_BYTE;
  assign r0_rdata = r0_rdata_q;
  assign r1_rdata = r1_rdata_q;

endmodule
